// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor
//   Run/halt monitor for the RISC-V CPU. After a start pulse it counts clock
//   cycles until a sentinel value appears on one watched register tap. When
//   the halt condition is met it latches the result tap, the cycle count and
//   a snapshot of every tap. If the CPU never halts, a watchdog ends the run.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous reset, active low (0 = reset)
//   start        in   begin or restart a run (level, sampled at the edge)
//   ack          in   return from DONE/TIMEOUT to IDLE
//   watch_bus    in   NUM_CH taps, channel k = [k*XLEN +: XLEN]
//   busy         out  1 while running
//   done         out  1 after the halt sentinel has been qualified
//   timeout      out  1 after the watchdog has fired
//   overflow     out  sticky: cycle_count saturated during this run
//   result       out  RESULT_CH tap latched at halt/timeout
//   cycle_count  out  cycles elapsed in the current or last run
//   snap_bus     out  all taps latched at halt/timeout
module cpu_run_monitor #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     NUM_CH     = 4,
    parameter int unsigned     HALT_CH    = 2,
    parameter int unsigned     RESULT_CH  = 1,
    parameter logic [XLEN-1:0] HALT_VALUE = '1,
    parameter int unsigned     HALT_HOLD  = 1,
    parameter int unsigned     CNT_W      = 16,
    parameter int unsigned     TIMEOUT    = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   ack,
    input  logic [NUM_CH*XLEN-1:0] watch_bus,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic                   overflow,
    output logic [XLEN-1:0]        result,
    output logic [CNT_W-1:0]       cycle_count,
    output logic [NUM_CH*XLEN-1:0] snap_bus
);

    // The hold counter never has to exceed HALT_HOLD.
    localparam int unsigned HOLD_W = (HALT_HOLD < 2) ? 1 : $clog2(HALT_HOLD + 1);

    // The watchdog is active only when its limit is reachable by the counter.
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    localparam bit              TO_EN   = (TIMEOUT != 0) && (64'(TIMEOUT) <= CNT_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_TOUT
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_ovf;
    logic [HOLD_W-1:0]        r_hold;
    logic [XLEN-1:0]          r_result;
    logic [NUM_CH*XLEN-1:0]   r_snap;

    logic [XLEN-1:0]          w_halt_tap;
    logic [XLEN-1:0]          w_res_tap;
    logic                     w_match;
    logic [HOLD_W-1:0]        w_hold_inc;
    logic                     w_halt;
    logic                     w_cnt_sat;
    logic [CNT_W-1:0]         w_cnt_inc;
    logic                     w_wdog;
    logic                     w_latch;
    logic                     w_clear;

    assign w_halt_tap = watch_bus[HALT_CH*XLEN +: XLEN];
    assign w_res_tap  = watch_bus[RESULT_CH*XLEN +: XLEN];
    assign w_match    = (w_halt_tap == HALT_VALUE);
    assign w_hold_inc = r_hold + HOLD_W'(1);
    // The edge that completes the hold run is itself the halting edge.
    assign w_halt     = w_match && (w_hold_inc == HOLD_W'(HALT_HOLD));

    assign w_cnt_sat  = (r_cnt == '1);
    assign w_cnt_inc  = w_cnt_sat ? r_cnt : r_cnt + CNT_W'(1);
    // Compare the post-increment count so that the limit edge itself fires.
    assign w_wdog     = TO_EN && (w_cnt_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                    w_clear      = 1'b1;
                end
            end
            S_RUN: begin
                // Halt takes priority over the watchdog on the same edge.
                if (w_halt) begin
                    w_state_next = S_DONE;
                    w_latch      = 1'b1;
                end else if (w_wdog) begin
                    w_state_next = S_TOUT;
                    w_latch      = 1'b1;
                end
            end
            S_DONE, S_TOUT: begin
                // Restart beats release when both arrive together.
                if (start) begin
                    w_state_next = S_RUN;
                    w_clear      = 1'b1;
                end else if (ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_hold   <= '0;
            r_result <= '0;
            r_snap   <= '0;
        end else if (w_clear) begin
            // result/snapshot survive a restart until the next latch.
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_hold <= '0;
        end else if (r_state == S_RUN) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_sat) begin
                r_ovf <= 1'b1;
            end
            r_hold <= w_match ? w_hold_inc : '0;
            if (w_latch) begin
                r_result <= w_res_tap;
                r_snap   <= watch_bus;
            end
        end
    end

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign timeout     = (r_state == S_TOUT);
    assign overflow    = r_ovf;
    assign result      = r_result;
    assign cycle_count = r_cnt;
    assign snap_bus    = r_snap;

endmodule
